mux_nto1_pipe: RTL and testbench

Parametrised, elastic two-stage N-to-1 word multiplexer for the Booth partial-product datapath.
- Selects one DATA_W-bit lane of a packed NUM_IN-lane bus per accepted beat.
- Carries valid/ready flow control so the select path can be retimed without stalling the multiplier pipeline.
- Flags out-of-range selects per beat and keeps a saturating error count.

---
 rtl/mux_nto1_pipe.sv | 156 +++++++++++++++
 tb/tb_mux_nto1_pipe.sv | 233 +++++++++++++++++++++++
 2 files changed

// File: rtl/mux_nto1_pipe.sv
// rtl/mux_nto1_pipe.sv - elastic two-stage N-to-1 lane multiplexer with select-error tracking
//
// Optional build: define MUX_PIPE_SKID_EN for a registered ready_o plus a
// one-entry skid register (3-beat capacity). The default build has 2-beat
// capacity and a combinational ready_i -> ready_o path.
//
// Ports:
//   clk_i, rst_n_i     clock, asynchronous active-low reset
//   valid_i/ready_o    input handshake; data_in_i (NUM_IN packed lanes), sel_i
//   valid_o/ready_i    output handshake; data_out_o, sel_err_o (sel >= NUM_IN)
//   err_cnt_o          saturating count of accepted out-of-range beats
//   err_clr_i          synchronous clear of err_cnt_o (wins over an increment)
module mux_nto1_pipe #(
   parameter int DATA_W = 9,
   parameter int NUM_IN = 8,
   parameter int SEL_W  = 3
) (
   input  logic                     clk_i,
   input  logic                     rst_n_i,
   input  logic                     valid_i,
   output logic                     ready_o,
   input  logic [NUM_IN*DATA_W-1:0] data_in_i,
   input  logic [SEL_W-1:0]         sel_i,
   output logic                     valid_o,
   input  logic                     ready_i,
   output logic [DATA_W-1:0]        data_out_o,
   output logic                     sel_err_o,
   output logic [7:0]               err_cnt_o,
   input  logic                     err_clr_i
);

   logic [DATA_W-1:0] lane;
   logic              sel_oor;
   logic              accept;
   logic              s2_load;
   logic              s1_valid;
   logic [DATA_W-1:0] s1_data;
   logic              s1_err;

   // Compare against every legal lane index so an out-of-range select never
   // forms an out-of-bounds part-select; no match leaves zeros and the error flag.
   always_comb begin
      lane    = '0;
      sel_oor = 1'b1;
      for (int k = 0; k < NUM_IN; k++) begin
         if (32'(sel_i) == 32'(k)) begin
            lane    = data_in_i[k*DATA_W +: DATA_W];
            sel_oor = 1'b0;
         end
      end
   end

   assign accept  = valid_i && ready_o;
   assign s2_load = !valid_o || ready_i;

`ifdef MUX_PIPE_SKID_EN
   logic              skid_valid;
   logic              skid_valid_nxt;
   logic [DATA_W-1:0] skid_data;
   logic              skid_err;
   logic              ready_q;

   // The skid only ever holds a beat younger than S1, so it refills S1 when
   // S1 advances, which keeps acceptance order.
   always_comb begin
      skid_valid_nxt = skid_valid;
      if (s1_valid && s2_load)
         skid_valid_nxt = skid_valid && accept;
      else if (s1_valid && accept)
         skid_valid_nxt = 1'b1;
   end

   assign ready_o = ready_q;

   always_ff @(posedge clk_i or negedge rst_n_i) begin
      if (!rst_n_i) begin
         s1_valid   <= 1'b0;
         s1_data    <= '0;
         s1_err     <= 1'b0;
         skid_valid <= 1'b0;
         skid_data  <= '0;
         skid_err   <= 1'b0;
         ready_q    <= 1'b0;
      end else begin
         skid_valid <= skid_valid_nxt;
         ready_q    <= !skid_valid_nxt;
         if (s1_valid && s2_load) begin
            if (skid_valid) begin
               s1_data <= skid_data;
               s1_err  <= skid_err;
               if (accept) begin
                  skid_data <= lane;
                  skid_err  <= sel_oor;
               end
            end else if (accept) begin
               s1_data <= lane;
               s1_err  <= sel_oor;
            end else begin
               s1_valid <= 1'b0;
            end
         end else if (!s1_valid) begin
            if (accept) begin
               s1_valid <= 1'b1;
               s1_data  <= lane;
               s1_err   <= sel_oor;
            end
         end else if (accept) begin
            skid_data <= lane;
            skid_err  <= sel_oor;
         end
      end
   end
`else
   // S1 may take a new beat whenever it is empty or its beat moves into S2.
   assign ready_o = !s1_valid || s2_load;

   always_ff @(posedge clk_i or negedge rst_n_i) begin
      if (!rst_n_i) begin
         s1_valid <= 1'b0;
         s1_data  <= '0;
         s1_err   <= 1'b0;
      end else if (accept) begin
         s1_valid <= 1'b1;
         s1_data  <= lane;
         s1_err   <= sel_oor;
      end else if (s2_load) begin
         s1_valid <= 1'b0;
      end
   end
`endif

   // Data is only refreshed by a real beat, so a bubble leaves the last word.
   always_ff @(posedge clk_i or negedge rst_n_i) begin
      if (!rst_n_i) begin
         valid_o    <= 1'b0;
         data_out_o <= '0;
         sel_err_o  <= 1'b0;
      end else if (s2_load) begin
         valid_o <= s1_valid;
         if (s1_valid) begin
            data_out_o <= s1_data;
            sel_err_o  <= s1_err;
         end
      end
   end

   always_ff @(posedge clk_i or negedge rst_n_i) begin
      if (!rst_n_i)
         err_cnt_o <= 8'd0;
      else if (err_clr_i)
         err_cnt_o <= 8'd0;
      else if (accept && sel_oor && err_cnt_o != 8'hFF)
         err_cnt_o <= err_cnt_o + 8'd1;
   end

endmodule

// File: tb/tb_mux_nto1_pipe.sv
// tb/tb_mux_nto1_pipe.sv - scoreboard bench for mux_nto1_pipe
module tb_mux_nto1_pipe;

   localparam int DATA_W = 9;
   localparam int NUM_IN = 5;
   localparam int SEL_W  = 3;
`ifdef MUX_PIPE_SKID_EN
   localparam int   CAP     = 3;
   localparam logic RST_RDY = 1'b0;
`else
   localparam int   CAP     = 2;
   localparam logic RST_RDY = 1'b1;
`endif

   logic                     clk = 1'b0;
   logic                     rst_n;
   logic                     valid_i;
   logic                     ready_o;
   logic [NUM_IN*DATA_W-1:0] data_in;
   logic [SEL_W-1:0]         sel_i;
   logic                     valid_o;
   logic                     ready_i;
   logic [DATA_W-1:0]        data_out_o;
   logic                     sel_err_o;
   logic [7:0]               err_cnt_o;
   logic                     err_clr;

   int total = 0;
   int bad   = 0;
   int n_acc = 0;
   logic [DATA_W:0]   q[$];
   logic [7:0]        exp_cnt = 8'd0;
   logic              hold_pend = 1'b0;
   logic [DATA_W+1:0] hold_val;

   mux_nto1_pipe #(.DATA_W(DATA_W), .NUM_IN(NUM_IN), .SEL_W(SEL_W)) dut (
      .clk_i      (clk),
      .rst_n_i    (rst_n),
      .valid_i    (valid_i),
      .ready_o    (ready_o),
      .data_in_i  (data_in),
      .sel_i      (sel_i),
      .valid_o    (valid_o),
      .ready_i    (ready_i),
      .data_out_o (data_out_o),
      .sel_err_o  (sel_err_o),
      .err_cnt_o  (err_cnt_o),
      .err_clr_i  (err_clr)
   );

   always #5 clk = ~clk;

   task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
      total++;
      if (got !== exp) begin
         bad++;
         $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
      end
   endtask

   task automatic step();
      @(posedge clk);
      #1;
   endtask

   task automatic fixed_lanes();
      for (int k = 0; k < NUM_IN; k++)
         data_in[k*DATA_W +: DATA_W] = DATA_W'(9'h100 + k);
   endtask

   task automatic rand_lanes();
      for (int k = 0; k < NUM_IN; k++)
         data_in[k*DATA_W +: DATA_W] = DATA_W'($urandom);
   endtask

   // Handshakes are decided at the next rising edge; inputs are stable here.
   always @(negedge clk) begin
      int s;
      logic [DATA_W:0] e;
      logic [DATA_W-1:0] d;
      if (rst_n) begin
         chk("err_cnt", 32'(err_cnt_o), 32'(exp_cnt));
         if (hold_pend)
            chk("hold", 32'({valid_o, sel_err_o, data_out_o}), 32'(hold_val));
         if (valid_o && ready_i) begin
            if (q.size() == 0) begin
               chk("unexpected_out", 32'd1, 32'd0);
            end else begin
               e = q.pop_front();
               chk("out_data", 32'(data_out_o), 32'(e[DATA_W-1:0]));
               chk("out_err", 32'(sel_err_o), 32'(e[DATA_W]));
            end
         end
         hold_pend = valid_o && !ready_i;
         hold_val  = {valid_o, sel_err_o, data_out_o};
         s = int'(sel_i);
         if (valid_i && ready_o) begin
            d = (s < NUM_IN) ? data_in[s*DATA_W +: DATA_W] : '0;
            q.push_back({(s >= NUM_IN), d});
            n_acc++;
         end
         if (err_clr)
            exp_cnt = 8'd0;
         else if (valid_i && ready_o && s >= NUM_IN && exp_cnt != 8'hFF)
            exp_cnt = exp_cnt + 8'd1;
      end
   end

   initial begin
      int acc;
      int start;
      int cyc;
      logic r0;
      rst_n = 1'b0; valid_i = 1'b0; ready_i = 1'b0; sel_i = '0; err_clr = 1'b0;
      fixed_lanes();
      #12;
      chk("rst_valid", 32'(valid_o), 32'd0);
      chk("rst_data", 32'(data_out_o), 32'd0);
      chk("rst_err", 32'(sel_err_o), 32'd0);
      chk("rst_cnt", 32'(err_cnt_o), 32'd0);
      chk("rst_ready", 32'(ready_o), 32'(RST_RDY));
      @(negedge clk);
      rst_n = 1'b1;
      step();

      // In-range stream at full rate, checking two-edge latency.
      ready_i = 1'b1;
      for (int k = 0; k <= NUM_IN; k++) begin
         valid_i = (k < NUM_IN);
         sel_i   = SEL_W'(k);
         step();
         if (k == 0)
            chk("lat_first", 32'(valid_o), 32'd0);
         else
            chk("stream", 32'({valid_o, data_out_o}), 32'h300 + 32'(k) - 32'd1);
      end
      valid_i = 1'b0;
      step();

      // Out-of-range select and counter saturation.
      valid_i = 1'b1; sel_i = 3'd6;
      step();
      valid_i = 1'b0;
      chk("cnt_one", 32'(err_cnt_o), 32'd1);
      step();
      chk("oor_beat", 32'({valid_o, sel_err_o, data_out_o}), 32'h600);
      valid_i = 1'b1;
      repeat (300) step();
      valid_i = 1'b0;
      chk("cnt_sat", 32'(err_cnt_o), 32'd255);

      // Clear wins over a same-cycle error beat.
      valid_i = 1'b1; err_clr = 1'b1;
      step();
      valid_i = 1'b0; err_clr = 1'b0;
      chk("clr_prio", 32'(err_cnt_o), 32'd0);
      repeat (3) step();

      // Stall: capacity and held output.
      ready_i = 1'b0;
      acc = 0;
      for (int i = 0; i < 10; i++) begin
         valid_i = 1'b1;
         sel_i   = SEL_W'(i % NUM_IN);
         rand_lanes();
         @(negedge clk);
         if (ready_o) acc++;
         step();
      end
      valid_i = 1'b0;
      chk("stall_acc", 32'(acc), 32'(CAP));
      chk("stall_ready", 32'(ready_o), 32'd0);
      ready_i = 1'b1;
      repeat (5) step();
      chk("stall_drain", 32'(q.size()), 32'd0);

      // Random traffic against the scoreboard.
      start = n_acc;
      cyc = 0;
      while ((n_acc - start) < 10000 && cyc < 60000) begin
         valid_i = ($urandom % 10) < 7;
         ready_i = ($urandom % 10) < 7;
         sel_i   = SEL_W'($urandom_range(0, 7));
         err_clr = ($urandom % 64) == 0;
         rand_lanes();
`ifdef MUX_PIPE_SKID_EN
         #1;
         r0 = ready_o;
         ready_i = !ready_i;
         #1;
         chk("no_comb_path", 32'(ready_o), 32'(r0));
         ready_i = !ready_i;
`endif
         step();
         cyc++;
      end
      valid_i = 1'b0; err_clr = 1'b0; ready_i = 1'b1;
      chk("rand_beats", 32'((n_acc - start) >= 10000), 32'd1);
      repeat (5) step();
      chk("rand_drain", 32'(q.size()), 32'd0);

      // Asynchronous reset mid-stream.
      ready_i = 1'b0; valid_i = 1'b1; sel_i = 3'd7;
      repeat (4) step();
      @(posedge clk);
      #3;
      rst_n = 1'b0;
      #1;
      chk("arst_valid", 32'(valid_o), 32'd0);
      chk("arst_data", 32'(data_out_o), 32'd0);
      chk("arst_cnt", 32'(err_cnt_o), 32'd0);
      q.delete();
      exp_cnt = 8'd0;
      hold_pend = 1'b0;
      valid_i = 1'b0; ready_i = 1'b1;
      fixed_lanes();
      @(negedge clk);
      rst_n = 1'b1;
      step();
      valid_i = 1'b1; sel_i = 3'd2;
      step();
      valid_i = 1'b0;
      chk("post_lat0", 32'(valid_o), 32'd0);
      step();
      chk("post_lat", 32'({valid_o, data_out_o}), 32'h302);
      repeat (3) step();
      chk("final_drain", 32'(q.size()), 32'd0);

      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule
